// File: rtl/rob_commit_buffer.sv
// In-order reorder buffer: allocates tags at the tail, gathers completions, retires the head in order.
// Define ROB_BYPASS_EN to let a same-cycle completion of the head retire immediately.

module rob_entry #(
  parameter int PHY_REG_BITS = 6,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    wr,
  input  logic                    wr_uses_rw,
  input  logic [PHY_REG_BITS-1:0] wr_phy_rw,
  input  logic [PHY_REG_BITS-1:0] wr_old_phy,
  input  logic                    wr_is_branch,
  input  logic                    rel,
  input  logic                    cmpl_hit,
  input  logic [DATA_WIDTH-1:0]   cmpl_data,
  input  logic                    cmpl_mispred,
  output logic                    valid,
  output logic                    done,
  output logic                    uses_rw,
  output logic [PHY_REG_BITS-1:0] phy_rw,
  output logic [PHY_REG_BITS-1:0] old_phy,
  output logic                    is_branch,
  output logic                    mispred,
  output logic [DATA_WIDTH-1:0]   data
);
  // wr only targets an invalid slot, so it never collides with cmpl_hit (gated by valid)
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
      done  <= 1'b0;
    end else begin
      if (rel)      valid <= 1'b0;
      if (cmpl_hit) done  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uses_rw   <= 1'b0;
      phy_rw    <= '0;
      old_phy   <= '0;
      is_branch <= 1'b0;
      mispred   <= 1'b0;
      data      <= '0;
    end else begin
      if (wr) begin
        uses_rw   <= wr_uses_rw;
        phy_rw    <= wr_phy_rw;
        old_phy   <= wr_old_phy;
        is_branch <= wr_is_branch;
      end
      if (cmpl_hit) begin
        mispred <= cmpl_mispred;
        data    <= cmpl_data;
      end
    end
  end
endmodule

module rob_commit_buffer #(
  parameter int ROB_DEPTH      = 16,
  parameter int ROB_DEPTH_BITS = 4,
  parameter int PHY_REG_BITS   = 6,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_valid,
  input  logic                      alloc_uses_rw,
  input  logic [PHY_REG_BITS-1:0]   alloc_phy_rw,
  input  logic [PHY_REG_BITS-1:0]   alloc_old_phy,
  input  logic                      alloc_is_branch,
  output logic                      alloc_ready,
  output logic [ROB_DEPTH_BITS-1:0] alloc_tag,
  input  logic                      cmpl_valid,
  input  logic [ROB_DEPTH_BITS-1:0] cmpl_tag,
  input  logic [DATA_WIDTH-1:0]     cmpl_data,
  input  logic                      cmpl_mispredict,
  output logic                      reg_wr_en,
  output logic [PHY_REG_BITS-1:0]   reg_wr_addr,
  output logic [DATA_WIDTH-1:0]     reg_wr_data,
  output logic [PHY_REG_BITS-1:0]   free_phy,
  output logic                      flush,
  output logic [ROB_DEPTH_BITS:0]   count,
  output logic                      empty
);
  localparam logic [ROB_DEPTH_BITS:0] FULL_CNT = (ROB_DEPTH_BITS+1)'(ROB_DEPTH);

  logic [ROB_DEPTH_BITS-1:0] head, tail;
  logic [ROB_DEPTH_BITS:0]   cnt;

  logic [ROB_DEPTH-1:0]                   e_valid, e_done, e_uses, e_br, e_mispred;
  logic [ROB_DEPTH-1:0][PHY_REG_BITS-1:0] e_phy, e_old;
  logic [ROB_DEPTH-1:0][DATA_WIDTH-1:0]   e_data;

  logic                  head_done, head_mispred;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  retire, mispredict_retire, alloc_fire;

`ifdef ROB_BYPASS_EN
  logic byp_hit;
  assign byp_hit      = cmpl_valid && (cmpl_tag == head);
  assign head_done    = e_done[head] || byp_hit;
  assign head_data    = byp_hit ? cmpl_data       : e_data[head];
  assign head_mispred = byp_hit ? cmpl_mispredict : e_mispred[head];
`else
  assign head_done    = e_done[head];
  assign head_data    = e_data[head];
  assign head_mispred = e_mispred[head];
`endif

  assign retire            = e_valid[head] && head_done;
  assign mispredict_retire = retire && e_br[head] && head_mispred;
  // A retire in the same cycle does not open a slot while full
  assign alloc_ready       = (cnt < FULL_CNT) && !mispredict_retire;
  assign alloc_fire        = alloc_valid && alloc_ready;
  assign alloc_tag         = tail;
  assign count             = cnt;
  assign empty             = (cnt == '0);

  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_ent
    localparam logic [ROB_DEPTH_BITS-1:0] IDX = ROB_DEPTH_BITS'(i);
    rob_entry #(.PHY_REG_BITS(PHY_REG_BITS), .DATA_WIDTH(DATA_WIDTH)) u_ent (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (mispredict_retire),
      .wr           (alloc_fire && (tail == IDX)),
      .wr_uses_rw   (alloc_uses_rw),
      .wr_phy_rw    (alloc_phy_rw),
      .wr_old_phy   (alloc_old_phy),
      .wr_is_branch (alloc_is_branch),
      .rel          (retire && (head == IDX)),
      .cmpl_hit     (cmpl_valid && (cmpl_tag == IDX) && e_valid[i]),
      .cmpl_data    (cmpl_data),
      .cmpl_mispred (cmpl_mispredict),
      .valid        (e_valid[i]),
      .done         (e_done[i]),
      .uses_rw      (e_uses[i]),
      .phy_rw       (e_phy[i]),
      .old_phy      (e_old[i]),
      .is_branch    (e_br[i]),
      .mispred      (e_mispred[i]),
      .data         (e_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || mispredict_retire) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (retire)     head <= head + 1'b1;
      if (alloc_fire) tail <= tail + 1'b1;
      case ({alloc_fire, retire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      free_phy    <= '0;
      flush       <= 1'b0;
    end else begin
      reg_wr_en <= retire && e_uses[head] && (e_phy[head] != '0);
      flush     <= mispredict_retire;
      if (retire) begin
        reg_wr_addr <= e_phy[head];
        reg_wr_data <= head_data;
        free_phy    <= e_old[head];
      end
    end
  end
endmodule

// File: tb/tb_rob_commit_buffer.sv
// Scoreboard bench for rob_commit_buffer: expected commits queued at allocation, checked on reg_wr_en.
module tb_rob_commit_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid, alloc_uses_rw, alloc_is_branch, alloc_ready;
  logic [5:0]  alloc_phy_rw, alloc_old_phy;
  logic [3:0]  alloc_tag;
  logic        cmpl_valid, cmpl_mispredict;
  logic [3:0]  cmpl_tag;
  logic [31:0] cmpl_data;
  logic        reg_wr_en, flush, empty;
  logic [5:0]  reg_wr_addr, free_phy;
  logic [31:0] reg_wr_data;
  logic [4:0]  count;

  rob_commit_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_uses_rw(alloc_uses_rw), .alloc_phy_rw(alloc_phy_rw),
    .alloc_old_phy(alloc_old_phy), .alloc_is_branch(alloc_is_branch),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
    .cmpl_mispredict(cmpl_mispredict),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .free_phy(free_phy), .flush(flush), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

`ifdef ROB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [5:0]  free;
  } commit_t;

  commit_t sb[$];
  commit_t mon_exp;
  int n_tests = 0, n_fail = 0;
  int commit_cnt = 0, flush_cnt = 0, commit_cyc = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Commit monitor: every reg_wr_en pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) flush_cnt++;
      if (reg_wr_en) begin
        commit_cnt++;
        commit_cyc = cyc;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_commit: got addr=%0d data=%h, required no commit", reg_wr_addr, reg_wr_data);
        end else begin
          mon_exp = sb.pop_front();
          if (reg_wr_addr !== mon_exp.addr || reg_wr_data !== mon_exp.data || free_phy !== mon_exp.free) begin
            n_fail++;
            $display("FAIL commit: got addr=%0d data=%h free=%0d, required addr=%0d data=%h free=%0d",
                     reg_wr_addr, reg_wr_data, free_phy, mon_exp.addr, mon_exp.data, mon_exp.free);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_uses_rw = 1'b0; alloc_phy_rw = '0;
    alloc_old_phy = '0; alloc_is_branch = 1'b0; cmpl_valid = 1'b0; cmpl_tag = '0;
    cmpl_data = '0; cmpl_mispredict = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic u, input logic [5:0] p, input logic [5:0] o, input logic br);
    alloc_valid = 1'b1; alloc_uses_rw = u; alloc_phy_rw = p; alloc_old_phy = o; alloc_is_branch = br;
    tick;
    alloc_valid = 1'b0;
  endtask

  task automatic cmpl(input logic [3:0] t, input logic [31:0] d, input logic mp);
    cmpl_valid = 1'b1; cmpl_tag = t; cmpl_data = d; cmpl_mispredict = mp;
    tick;
    cmpl_valid = 1'b0; cmpl_mispredict = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge clk);
    n_tests++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b, required 0", reg_wr_en); end
    n_tests++; if (reg_wr_addr !== 6'd0) begin n_fail++; $display("FAIL rst_wr_addr: got %0d, required 0", reg_wr_addr); end
    n_tests++; if (reg_wr_data !== 32'd0) begin n_fail++; $display("FAIL rst_wr_data: got %h, required 0", reg_wr_data); end
    n_tests++; if (free_phy !== 6'd0) begin n_fail++; $display("FAIL rst_free_phy: got %0d, required 0", free_phy); end
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b, required 0", flush); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b, required 1", empty); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", count); end
    n_tests++; if (alloc_tag !== 4'd0) begin n_fail++; $display("FAIL rst_alloc_tag: got %0d, required 0", alloc_tag); end
    n_tests++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_alloc_ready: got %b, required 1", alloc_ready); end
  endtask

  task automatic test_in_order;
    int c0;
    do_reset;
    c0 = commit_cnt;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (alloc_tag !== 4'(i)) begin n_fail++; $display("FAIL io_tag: got %0d, required %0d", alloc_tag, i); end
      alloc(1'b1, 6'(33 + i), 6'(1 + i), 1'b0);
      sb.push_back('{6'(33 + i), 32'(32'hA + i), 6'(1 + i)});
    end
    @(negedge clk);
    n_tests++; if (count !== 5'd3) begin n_fail++; $display("FAIL io_count: got %0d, required 3", count); end
    n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL io_empty: got %b, required 0", empty); end
    repeat (3) tick;
    n_tests++; if (commit_cnt !== c0) begin n_fail++; $display("FAIL io_early_commit: got %0d commits, required 0", commit_cnt - c0); end
    cmpl(4'd2, 32'hC, 1'b0);
    cmpl(4'd1, 32'hB, 1'b0);
    cmpl(4'd0, 32'hA, 1'b0);
    wait_drain(20);
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL io_drain: got %0d pending, required 0", sb.size()); end
    tick; tick;
    @(negedge clk);
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL io_count_end: got %0d, required 0", count); end
  endtask

  task automatic test_full_wrap;
    logic exp_rdy;
    do_reset;
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (alloc_ready !== 1'b1 || alloc_tag !== 4'(i)) begin
        n_fail++; $display("FAIL fill_tag: got ready=%b tag=%0d, required ready=1 tag=%0d", alloc_ready, alloc_tag, i);
      end
      alloc(1'b1, 6'(10 + i), 6'(i), 1'b0);
      sb.push_back('{6'(10 + i), 32'(32'h100 + i), 6'(i)});
    end
    @(negedge clk);
    n_tests++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b, required 0", alloc_ready); end
    n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d, required 16", count); end
    alloc(1'b1, 6'd50, 6'd50, 1'b0);
    @(negedge clk);
    n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL full_drop: got %0d, required 16", count); end
    cmpl(4'd0, 32'h100, 1'b0);
`ifdef ROB_BYPASS_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    @(negedge clk);
    n_tests++; if (alloc_ready !== exp_rdy) begin n_fail++; $display("FAIL full_retire_ready: got %b, required %b", alloc_ready, exp_rdy); end
    tick;
    @(negedge clk);
    n_tests++; if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0 || count !== 5'd15) begin
      n_fail++; $display("FAIL wrap: got ready=%b tag=%0d count=%0d, required ready=1 tag=0 count=15", alloc_ready, alloc_tag, count);
    end
    #1;
    alloc(1'b1, 6'd40, 6'd41, 1'b0);
    sb.push_back('{6'd40, 32'h200, 6'd41});
    for (int i = 1; i < 16; i++) cmpl(4'(i), 32'(32'h100 + i), 1'b0);
    cmpl(4'd0, 32'h200, 1'b0);
    wait_drain(60);
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL wrap_drain: got %0d pending, required 0", sb.size()); end
    tick; tick;
    @(negedge clk);
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL wrap_count_end: got %0d, required 0", count); end
  endtask

  task automatic test_flush;
    int f0, c0, k;
    do_reset;
    f0 = flush_cnt; c0 = commit_cnt;
    alloc(1'b1, 6'd20, 6'd5, 1'b0);
    sb.push_back('{6'd20, 32'h55, 6'd5});
    alloc(1'b0, 6'd0, 6'd6, 1'b1);
    for (int i = 2; i < 6; i++) alloc(1'b1, 6'(21 + i), 6'(i), 1'b0);
    for (int i = 2; i < 6; i++) cmpl(4'(i), 32'(32'h300 + i), 1'b0);
    cmpl(4'd1, 32'h0, 1'b1);
    cmpl(4'd0, 32'h55, 1'b0);
    k = 0;
    while (flush_cnt == f0 && k < 20) begin @(negedge clk); #1; k++; end
    repeat (3) tick;
    @(negedge clk);
    n_tests++; if (flush_cnt - f0 !== 1) begin n_fail++; $display("FAIL flush_pulses: got %0d, required 1", flush_cnt - f0); end
    n_tests++; if (commit_cnt - c0 !== 1) begin n_fail++; $display("FAIL flush_commits: got %0d, required 1", commit_cnt - c0); end
    n_tests++; if (count !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_count: got count=%0d empty=%b, required 0/1", count, empty); end
    n_tests++; if (alloc_tag !== 4'd0) begin n_fail++; $display("FAIL flush_tag: got %0d, required 0", alloc_tag); end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL flush_sb: got %0d pending, required 0", sb.size()); end
    #1;
    alloc(1'b1, 6'd30, 6'd31, 1'b0);
    sb.push_back('{6'd30, 32'h30, 6'd31});
    cmpl(4'd0, 32'h30, 1'b0);
    wait_drain(20);
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL post_flush_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_no_write;
    int c0;
    do_reset;
    c0 = commit_cnt;
    alloc(1'b0, 6'd7, 6'd8, 1'b0);
    alloc(1'b1, 6'd0, 6'd9, 1'b0);
    alloc(1'b1, 6'd9, 6'd10, 1'b0);
    sb.push_back('{6'd9, 32'h99, 6'd10});
    cmpl(4'd0, 32'h77, 1'b0);
    cmpl(4'd1, 32'h88, 1'b0);
    cmpl(4'd2, 32'h99, 1'b0);
    wait_drain(20);
    repeat (3) tick;
    @(negedge clk);
    n_tests++; if (commit_cnt - c0 !== 1) begin n_fail++; $display("FAIL nowr_commits: got %0d, required 1", commit_cnt - c0); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL nowr_count: got %0d, required 0", count); end
    n_tests++; if (alloc_tag !== 4'd3) begin n_fail++; $display("FAIL nowr_tag: got %0d, required 3", alloc_tag); end
  endtask

  task automatic test_reset_mid;
    int c0;
    do_reset;
    c0 = commit_cnt;
    alloc(1'b1, 6'd11, 6'd1, 1'b0);
    alloc(1'b1, 6'd12, 6'd2, 1'b0);
    @(negedge clk);
    n_tests++; if (count !== 5'd2) begin n_fail++; $display("FAIL mid_count_pre: got %0d, required 2", count); end
    #1;
    do_reset;
    repeat (3) tick;
    @(negedge clk);
    n_tests++; if (count !== 5'd0 || empty !== 1'b1 || alloc_tag !== 4'd0) begin
      n_fail++; $display("FAIL mid_reset: got count=%0d empty=%b tag=%0d, required 0/1/0", count, empty, alloc_tag);
    end
    n_tests++; if (commit_cnt !== c0) begin n_fail++; $display("FAIL mid_commits: got %0d, required 0", commit_cnt - c0); end
  endtask

  task automatic test_latency;
    int c0, cn, k;
    do_reset;
    alloc(1'b1, 6'd12, 6'd13, 1'b0);
    sb.push_back('{6'd12, 32'h77, 6'd13});
    tick;
    c0 = commit_cnt;
    cmpl_valid = 1'b1; cmpl_tag = 4'd0; cmpl_data = 32'h77; cmpl_mispredict = 1'b0;
    @(negedge clk);
    cn = cyc;
    @(posedge clk); #1;
    cmpl_valid = 1'b0;
    k = 0;
    while (commit_cnt == c0 && k < 10) begin @(negedge clk); #1; k++; end
    n_tests++; if (commit_cnt == c0 || commit_cyc - cn !== LAT) begin
      n_fail++; $display("FAIL latency: got %0d cycles (commits=%0d), required %0d", commit_cyc - cn, commit_cnt - c0, LAT);
    end
  endtask

  initial begin
    test_reset;
    test_in_order;
    test_full_wrap;
    test_flush;
    test_no_write;
    test_reset_mid;
    test_latency;
    repeat (3) tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
